// File: rtl/apb_arb2.sv
// Two-master, one-slave APB arbiter: round-robin grant held for a whole transfer,
// with a per-transfer watchdog that aborts a silent slave with pslverr.
module apb_arb2 #(
   parameter int P_ADDR_W = 32,
   parameter int P_DATA_W = 32,
   parameter int P_STRB_W = 4,
   parameter int TIMEOUT  = 1024,
   parameter int CNT_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                m0_psel,
   input  logic                m0_penable,
   input  logic                m0_pwrite,
   input  logic [P_ADDR_W-1:0] m0_paddr,
   input  logic [P_DATA_W-1:0] m0_pwdata,
   input  logic [P_STRB_W-1:0] m0_pstrb,
   output logic                m0_pready,
   output logic [P_DATA_W-1:0] m0_prdata,
   output logic                m0_pslverr,
   input  logic                m1_psel,
   input  logic                m1_penable,
   input  logic                m1_pwrite,
   input  logic [P_ADDR_W-1:0] m1_paddr,
   input  logic [P_DATA_W-1:0] m1_pwdata,
   input  logic [P_STRB_W-1:0] m1_pstrb,
   output logic                m1_pready,
   output logic [P_DATA_W-1:0] m1_prdata,
   output logic                m1_pslverr,
   output logic                s_psel,
   output logic                s_penable,
   output logic                s_pwrite,
   output logic [P_ADDR_W-1:0] s_paddr,
   output logic [P_DATA_W-1:0] s_pwdata,
   output logic [P_STRB_W-1:0] s_pstrb,
   input  logic                s_pready,
   input  logic [P_DATA_W-1:0] s_prdata,
   input  logic                s_pslverr,
   output logic                timeout_evt
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] RESP   = 2'd3;

   localparam bit               WDOG_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [1:0]       state_r;
   logic             rr_last_r;
   logic             grant_r;
   logic [CNT_W-1:0] cnt_r;
   logic             req_s;
   logic             grant_s;
   logic             timeout_hit_s;
   logic             unused_penable_s;

   // penable is part of the master handshake but the grant only looks at psel
   assign unused_penable_s = m0_penable ^ m1_penable;

   // Round-robin pick and watchdog limit detection
   always_comb begin
      req_s         = m0_psel | m1_psel;
      grant_s       = 1'b0;
      timeout_hit_s = 1'b0;
      if (m0_psel && m1_psel) begin
         grant_s = ~rr_last_r;
      end else begin
         grant_s = m1_psel;
      end
      if (WDOG_EN && (cnt_r == CNT_LIMIT)) begin
         timeout_hit_s = 1'b1;
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Transfer FSM; every output is a register updated on the state transitions
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         rr_last_r   <= 1'b1;
         grant_r     <= 1'b0;
         cnt_r       <= '0;
         s_psel      <= 1'b0;
         s_penable   <= 1'b0;
         s_pwrite    <= 1'b0;
         s_paddr     <= '0;
         s_pwdata    <= '0;
         s_pstrb     <= '0;
         m0_pready   <= 1'b0;
         m0_prdata   <= '0;
         m0_pslverr  <= 1'b0;
         m1_pready   <= 1'b0;
         m1_prdata   <= '0;
         m1_pslverr  <= 1'b0;
         timeout_evt <= 1'b0;
      end else begin
         m0_pready   <= 1'b0;
         m0_pslverr  <= 1'b0;
         m1_pready   <= 1'b0;
         m1_pslverr  <= 1'b0;
         timeout_evt <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_s) begin
                  grant_r   <= grant_s;
                  rr_last_r <= grant_s;
                  s_pwrite  <= grant_s ? m1_pwrite : m0_pwrite;
                  s_paddr   <= grant_s ? m1_paddr  : m0_paddr;
                  s_pwdata  <= grant_s ? m1_pwdata : m0_pwdata;
                  s_pstrb   <= grant_s ? m1_pstrb  : m0_pstrb;
                  s_psel    <= 1'b1;
                  s_penable <= 1'b0;
                  state_r   <= SETUP;
               end else begin
                  state_r <= IDLE;
               end
            end
            SETUP: begin
               s_penable <= 1'b1;
               cnt_r     <= '0;
               state_r   <= ACCESS;
            end
            ACCESS: begin
               if (cnt_r != CNT_MAX) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
               // a slave answering on the limit cycle wins over the abort
               if (s_pready || timeout_hit_s) begin
                  s_psel      <= 1'b0;
                  s_penable   <= 1'b0;
                  timeout_evt <= ~s_pready;
                  state_r     <= RESP;
                  if (grant_r) begin
                     m1_pready  <= 1'b1;
                     m1_prdata  <= s_pready ? s_prdata : '0;
                     m1_pslverr <= s_pready ? s_pslverr : 1'b1;
                  end else begin
                     m0_pready  <= 1'b1;
                     m0_prdata  <= s_pready ? s_prdata : '0;
                     m0_pslverr <= s_pready ? s_pslverr : 1'b1;
                  end
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               s_psel    <= 1'b0;
               s_penable <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_arb2.sv
// Self-checking bench for apb_arb2: scenario tasks plus a response scoreboard
// fed at request time and drained whenever a master sees pready.
module tb_apb_arb2;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   typedef struct {
      bit          mst;
      logic [31:0] prdata;
      logic        pslverr;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset = 1'b1;
   logic          m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
   logic [AW-1:0] m0_paddr = '0;
   logic [DW-1:0] m0_pwdata = '0;
   logic [SW-1:0] m0_pstrb = '0;
   logic          m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
   logic [AW-1:0] m1_paddr = '0;
   logic [DW-1:0] m1_pwdata = '0;
   logic [SW-1:0] m1_pstrb = '0;
   logic          m0_pready, m0_pslverr, m1_pready, m1_pslverr;
   logic [DW-1:0] m0_prdata, m1_prdata;
   logic          s_psel, s_penable, s_pwrite;
   logic [AW-1:0] s_paddr;
   logic [DW-1:0] s_pwdata;
   logic [SW-1:0] s_pstrb;
   logic          s_pready = 1'b0;
   logic [DW-1:0] s_prdata = '0;
   logic          s_pslverr = 1'b0;
   logic          timeout_evt;

   int checks = 0;
   int errors = 0;
   int resp_cnt = 0;
   exp_t sb_q[$];
   exp_t mon_e;

   int          slv_wait = 0;
   int          wait_cnt = 0;
   logic [31:0] slv_key = 32'h0;
   logic        slv_err = 1'b0;

   apb_arb2 #(.P_ADDR_W(AW), .P_DATA_W(DW), .P_STRB_W(SW), .TIMEOUT(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
      .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
      .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
      .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
      .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
      .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
      .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
      .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
      .timeout_evt(timeout_evt)
   );

   // Slave model: answers after slv_wait wait states, data = paddr ^ slv_key
   always @(negedge clk) begin
      if (s_psel && s_penable) begin
         if (wait_cnt >= slv_wait) begin
            s_pready  = 1'b1;
            s_prdata  = s_paddr ^ slv_key;
            s_pslverr = slv_err;
         end else begin
            s_pready  = 1'b0;
            s_prdata  = '0;
            s_pslverr = 1'b0;
            wait_cnt++;
         end
      end else begin
         s_pready  = 1'b0;
         s_prdata  = '0;
         s_pslverr = 1'b0;
         wait_cnt  = 0;
      end
   end

   // Scoreboard drain: every master pready must match the oldest expectation
   always @(negedge clk) begin
      if (m0_pready || m1_pready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: m0_pready=%0b m1_pready=%0b, required no response",
                     m0_pready, m1_pready);
         end else begin
            mon_e = sb_q.pop_front();
            if ((m0_pready && m1_pready) || (m1_pready !== mon_e.mst) ||
                ((m1_pready ? m1_prdata : m0_prdata) !== mon_e.prdata) ||
                ((m1_pready ? m1_pslverr : m0_pslverr) !== mon_e.pslverr) ||
                ((m1_pready ? m0_pslverr : m1_pslverr) !== 1'b0)) begin
               errors++;
               $display("FAIL sb_resp: got m%0d data=%h err=%b (other err=%b), required m%0d data=%h err=%b",
                        m1_pready, m1_pready ? m1_prdata : m0_prdata,
                        m1_pready ? m1_pslverr : m0_pslverr,
                        m1_pready ? m0_pslverr : m1_pslverr,
                        mon_e.mst, mon_e.prdata, mon_e.pslverr);
            end
         end
         resp_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push_exp(input bit mst, input logic [31:0] d, input logic e);
      exp_t x;
      x.mst = mst;
      x.prdata = d;
      x.pslverr = e;
      sb_q.push_back(x);
   endtask

   // Waits (bounded) for n more responses; cyc = ticks taken, got = responses seen
   task automatic wait_resp(input int n, input int budget, output int cyc, output int got);
      int start;
      start = resp_cnt;
      cyc = 0;
      while ((resp_cnt - start) < n && cyc < budget) begin
         tick();
         cyc++;
      end
      got = resp_cnt - start;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks++;
      if ({s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, m0_pready, m1_pready,
           m0_prdata, m1_prdata, m0_pslverr, m1_pslverr, timeout_evt} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: s_psel=%b s_paddr=%h m0_prdata=%h m0_pready=%b, required all 0",
                  s_psel, s_paddr, m0_prdata, m0_pready);
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({s_psel, m0_pready, m1_pready, timeout_evt} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_idle: s_psel=%b m0_pready=%b m1_pready=%b, required 0", s_psel, m0_pready, m1_pready);
      end
   endtask

   task automatic test_single_read();
      slv_wait = 0;
      slv_key = 32'hCEAD_BEEF;
      slv_err = 1'b0;
      push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
      m0_psel = 1'b1;
      m0_pwrite = 1'b0;
      m0_paddr = 32'h1000_0000;
      tick();
      checks++;
      if (s_psel !== 1'b1 || s_penable !== 1'b0 || s_paddr !== 32'h1000_0000 || s_pwrite !== 1'b0) begin
         errors++;
         $display("FAIL read_setup: psel=%b penable=%b paddr=%h, required 1 0 10000000", s_psel, s_penable, s_paddr);
      end
      m0_penable = 1'b1;
      tick();
      checks++;
      if (s_psel !== 1'b1 || s_penable !== 1'b1) begin
         errors++;
         $display("FAIL read_access: psel=%b penable=%b, required 1 1", s_psel, s_penable);
      end
      tick();
      checks++;
      if (m0_pready !== 1'b1 || m0_prdata !== 32'hDEAD_BEEF || m0_pslverr !== 1'b0 || s_psel !== 1'b0) begin
         errors++;
         $display("FAIL read_resp: pready=%b prdata=%h pslverr=%b s_psel=%b, required 1 deadbeef 0 0",
                  m0_pready, m0_prdata, m0_pslverr, s_psel);
      end
      m0_psel = 1'b0;
      m0_penable = 1'b0;
      tick();
      checks++;
      if (m0_pready !== 1'b0 || m0_prdata !== 32'hDEAD_BEEF || m1_prdata !== 32'h0) begin
         errors++;
         $display("FAIL read_hold: pready=%b prdata=%h m1_prdata=%h, required 0 deadbeef 0",
                  m0_pready, m0_prdata, m1_prdata);
      end
   endtask

   task automatic test_round_robin();
      int cyc, got;
      do_reset();
      slv_wait = 0;
      slv_key = 32'h0BAD_F00D;
      slv_err = 1'b0;
      for (int i = 0; i < 2; i++) begin
         push_exp(1'b0, 32'h0000_0100 ^ 32'h0BAD_F00D, 1'b0);
         push_exp(1'b1, 32'h0000_0200 ^ 32'h0BAD_F00D, 1'b0);
      end
      m0_paddr = 32'h0000_0100;
      m1_paddr = 32'h0000_0200;
      m0_psel = 1'b1;
      m1_psel = 1'b1;
      wait_resp(4, 40, cyc, got);
      checks++;
      if (got != 4 || cyc != 15 || m1_pready !== 1'b1) begin
         errors++;
         $display("FAIL rr_timing: responses=%0d last_cycle=%0d m1_pready=%b, required 4 15 1", got, cyc, m1_pready);
      end
      m0_psel = 1'b0;
      m1_psel = 1'b0;
      tick();
   endtask

   task automatic test_write_stable();
      int cyc, bad;
      slv_wait = 3;
      slv_key = 32'h0000_1111;
      slv_err = 1'b1;
      push_exp(1'b1, 32'h0000_1101, 1'b1);
      m1_psel = 1'b1;
      m1_pwrite = 1'b1;
      m1_paddr = 32'h0000_0010;
      m1_pwdata = 32'h0000_55AA;
      m1_pstrb = 4'h3;
      tick();
      cyc = 1;
      bad = 0;
      m1_paddr = 32'hFFFF_FFF0;
      m1_pwdata = 32'h0;
      m1_pstrb = 4'hC;
      m1_pwrite = 1'b0;
      while (m1_pready !== 1'b1 && cyc < 20) begin
         if (s_psel !== 1'b1 || s_paddr !== 32'h0000_0010 || s_pstrb !== 4'h3 ||
             s_pwdata !== 32'h0000_55AA || s_pwrite !== 1'b1) begin
            bad++;
         end
         tick();
         cyc++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL write_payload: %0d unstable cycles, required 0", bad);
      end
      checks++;
      if (cyc != 6 || m1_pslverr !== 1'b1 || m0_pready !== 1'b0) begin
         errors++;
         $display("FAIL write_latency: cycle=%0d pslverr=%b m0_pready=%b, required 6 1 0", cyc, m1_pslverr, m0_pready);
      end
      m1_psel = 1'b0;
      m1_pwrite = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int cyc, got;
      slv_wait = 1000;
      slv_err = 1'b0;
      push_exp(1'b0, 32'h0, 1'b1);
      m0_psel = 1'b1;
      m0_paddr = 32'h0000_0020;
      wait_resp(1, 30, cyc, got);
      checks++;
      if (got != 1 || cyc != 10) begin
         errors++;
         $display("FAIL timeout_latency: responses=%0d cycle=%0d, required 1 10", got, cyc);
      end
      checks++;
      if (timeout_evt !== 1'b1 || m0_pslverr !== 1'b1 || m0_prdata !== 32'h0 || s_psel !== 1'b0) begin
         errors++;
         $display("FAIL timeout_resp: evt=%b pslverr=%b prdata=%h s_psel=%b, required 1 1 0 0",
                  timeout_evt, m0_pslverr, m0_prdata, s_psel);
      end
      m0_psel = 1'b0;
      tick();
      checks++;
      if (timeout_evt !== 1'b0 || m0_pready !== 1'b0) begin
         errors++;
         $display("FAIL timeout_pulse: evt=%b pready=%b, required 0 0", timeout_evt, m0_pready);
      end
   endtask

   task automatic test_timeout_race();
      int cyc, got;
      slv_wait = 7;
      slv_key = 32'h1234_0000;
      slv_err = 1'b0;
      push_exp(1'b0, 32'h1234_0030, 1'b0);
      m0_psel = 1'b1;
      m0_paddr = 32'h0000_0030;
      wait_resp(1, 30, cyc, got);
      checks++;
      if (got != 1 || cyc != 10 || timeout_evt !== 1'b0 || m0_prdata !== 32'h1234_0030 || m0_pslverr !== 1'b0) begin
         errors++;
         $display("FAIL race_resp: responses=%0d cycle=%0d evt=%b prdata=%h err=%b, required 1 10 0 12340030 0",
                  got, cyc, timeout_evt, m0_prdata, m0_pslverr);
      end
      m0_psel = 1'b0;
      tick();
      checks++;
      if (timeout_evt !== 1'b0) begin
         errors++;
         $display("FAIL race_evt: evt=%b, required 0", timeout_evt);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, got;
      slv_wait = 1000;
      slv_key = 32'h0;
      m0_psel = 1'b1;
      m0_paddr = 32'h0000_0040;
      tick();
      tick();
      checks++;
      if (s_penable !== 1'b1) begin
         errors++;
         $display("FAIL midrst_access: s_penable=%b, required 1", s_penable);
      end
      reset = 1'b1;
      m0_psel = 1'b0;
      tick();
      checks++;
      if ({s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, m0_pready, m1_pready,
           m0_prdata, m1_prdata, m0_pslverr, m1_pslverr, timeout_evt} !== '0) begin
         errors++;
         $display("FAIL midrst_outputs: s_psel=%b s_penable=%b s_paddr=%h m0_pready=%b, required all 0",
                  s_psel, s_penable, s_paddr, m0_pready);
      end
      reset = 1'b0;
      repeat (3) tick();
      slv_wait = 0;
      push_exp(1'b0, 32'h0000_0040, 1'b0);
      push_exp(1'b1, 32'h0000_0080, 1'b0);
      m0_psel = 1'b1;
      m1_psel = 1'b1;
      m1_paddr = 32'h0000_0080;
      tick();
      checks++;
      if (s_psel !== 1'b1 || s_paddr !== 32'h0000_0040) begin
         errors++;
         $display("FAIL midrst_first_grant: s_psel=%b s_paddr=%h, required 1 00000040", s_psel, s_paddr);
      end
      wait_resp(2, 30, cyc, got);
      m0_psel = 1'b0;
      m1_psel = 1'b0;
      checks++;
      if (got != 2) begin
         errors++;
         $display("FAIL midrst_resps: responses=%0d, required 2", got);
      end
      repeat (3) tick();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_stable();
      test_timeout();
      test_timeout_race();
      test_reset_mid();
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: %0d pending expectations, required 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
